// File: rtl/manchester_rx_decoder.sv
// Manchester II word decoder: synchronises the bus pair, hunts for a 3-bit-time
// sync in a sample history, then resolves 16 data bits plus odd parity.
module manchester_rx_decoder #(
    parameter int SPB       = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 dec_clk,
    input  logic                 reset_n,
    input  logic                 rx_p,
    input  logic                 rx_n,
    input  logic                 enable,
    output logic [DATA_BITS-1:0] word_data,
    output logic                 word_csw,
    output logic                 word_valid,
    output logic                 parity_err,
    output logic                 manch_err,
    output logic                 rx_busy
);

    localparam int HIST_W    = 3 * SPB;
    localparam int HALF_SYNC = 3 * SPB / 2;
    localparam int CW        = $clog2(SPB);
    localparam int BW        = $clog2(DATA_BITS + 1);

    localparam logic [HIST_W-1:0] CSW_SYNC  = {{HALF_SYNC{1'b1}}, {HALF_SYNC{1'b0}}};
    localparam logic [HIST_W-1:0] DATA_SYNC = ~CSW_SYNC;

    localparam logic [CW-1:0] FIRST_SAMPLE  = CW'(SPB / 4);
    localparam logic [CW-1:0] SECOND_SAMPLE = CW'(3 * SPB / 4);
    localparam logic [CW-1:0] LAST_SAMPLE   = CW'(SPB - 1);
    localparam logic [BW-1:0] PARITY_BIT    = BW'(DATA_BITS);

    typedef enum logic {
        HUNT,
        BITS
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_p_meta_q, rx_p_meta_d;
    logic                  rx_p_sync_q, rx_p_sync_d;
    logic                  rx_n_meta_q, rx_n_meta_d;
    logic                  rx_n_sync_q, rx_n_sync_d;
    logic [HIST_W-1:0]     hist_q, hist_d;
    logic [CW-1:0]         samp_cnt_q, samp_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  first_half_q, first_half_d;
    logic                  second_half_q, second_half_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  csw_q, csw_d;
    logic                  par_acc_q, par_acc_d;
    logic                  merr_acc_q, merr_acc_d;
    logic [DATA_BITS-1:0]  word_data_q, word_data_d;
    logic                  word_csw_q, word_csw_d;
    logic                  word_valid_q, word_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  manch_err_q, manch_err_d;

    logic                  line_lvl;
    logic                  csw_match;
    logic                  data_match;
    logic                  bit_val;
    logic                  halves_equal;

    always_comb begin
        rx_p_meta_d   = rx_p;
        rx_p_sync_d   = rx_p_meta_q;
        rx_n_meta_d   = rx_n;
        rx_n_sync_d   = rx_n_meta_q;

        // Both legs high (undriven/fault) must read as idle, hence AND NOT.
        line_lvl      = rx_p_sync_q & ~rx_n_sync_q;
        hist_d        = {hist_q[HIST_W-2:0], line_lvl};
        csw_match     = (hist_q == CSW_SYNC);
        data_match    = (hist_q == DATA_SYNC);
        bit_val       = first_half_q;
        halves_equal  = (first_half_q == second_half_q);

        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        first_half_d  = first_half_q;
        second_half_d = second_half_q;
        shift_d       = shift_q;
        csw_d         = csw_q;
        par_acc_d     = par_acc_q;
        merr_acc_d    = merr_acc_q;
        word_data_d   = word_data_q;
        word_csw_d    = word_csw_q;
        word_valid_d  = 1'b0;
        parity_err_d  = parity_err_q;
        manch_err_d   = manch_err_q;

        case (state_q)
            HUNT: begin
                if (enable && (csw_match || data_match)) begin
                    state_d    = BITS;
                    csw_d      = csw_match;
                    samp_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_acc_d  = 1'b0;
                    merr_acc_d = 1'b0;
                end
            end
            BITS: begin
                if (!enable) begin
                    state_d = HUNT;
                end else begin
                    samp_cnt_d = samp_cnt_q + CW'(1);
                    if (samp_cnt_q == FIRST_SAMPLE) first_half_d = hist_q[0];
                    if (samp_cnt_q == SECOND_SAMPLE) second_half_d = hist_q[0];
                    if (samp_cnt_q == LAST_SAMPLE) begin
                        samp_cnt_d = '0;
                        par_acc_d  = par_acc_q ^ bit_val;
                        merr_acc_d = merr_acc_q | halves_equal;
                        if (bit_cnt_q == PARITY_BIT) begin
                            // Odd parity: an even running XOR including the parity bit is an error.
                            state_d      = HUNT;
                            word_valid_d = 1'b1;
                            word_data_d  = shift_q;
                            word_csw_d   = csw_q;
                            parity_err_d = ~(par_acc_q ^ bit_val);
                            manch_err_d  = merr_acc_q | halves_equal;
                        end else begin
                            shift_d   = {shift_q[DATA_BITS-2:0], bit_val};
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge dec_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            rx_p_meta_q   <= 1'b0;
            rx_p_sync_q   <= 1'b0;
            rx_n_meta_q   <= 1'b0;
            rx_n_sync_q   <= 1'b0;
            hist_q        <= '0;
            samp_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            first_half_q  <= 1'b0;
            second_half_q <= 1'b0;
            shift_q       <= '0;
            csw_q         <= 1'b0;
            par_acc_q     <= 1'b0;
            merr_acc_q    <= 1'b0;
            word_data_q   <= '0;
            word_csw_q    <= 1'b0;
            word_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            manch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_p_meta_q   <= rx_p_meta_d;
            rx_p_sync_q   <= rx_p_sync_d;
            rx_n_meta_q   <= rx_n_meta_d;
            rx_n_sync_q   <= rx_n_sync_d;
            hist_q        <= hist_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            first_half_q  <= first_half_d;
            second_half_q <= second_half_d;
            shift_q       <= shift_d;
            csw_q         <= csw_d;
            par_acc_q     <= par_acc_d;
            merr_acc_q    <= merr_acc_d;
            word_data_q   <= word_data_d;
            word_csw_q    <= word_csw_d;
            word_valid_q  <= word_valid_d;
            parity_err_q  <= parity_err_d;
            manch_err_q   <= manch_err_d;
        end
    end

    assign word_data  = word_data_q;
    assign word_csw   = word_csw_q;
    assign word_valid = word_valid_q;
    assign parity_err = parity_err_q;
    assign manch_err  = manch_err_q;
    assign rx_busy    = (state_q == BITS);

endmodule

// File: tb/tb_manchester_rx_decoder.sv
// Self-checking bench for manchester_rx_decoder: builds wire waveforms from word
// descriptions and checks each word_valid pulse against a queue of expected words.
module tb_manchester_rx_decoder;

    localparam int SPB        = 8;
    localparam int DATA_BITS  = 16;
    localparam int LATENCY    = (DATA_BITS + 1) * SPB + 1;
    // Edges from driving a sample until the history register holds it.
    localparam int PIPE_EDGES = 3;

    logic                 dec_clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 rx_p    = 1'b0;
    logic                 rx_n    = 1'b0;
    logic                 enable  = 1'b0;
    logic [DATA_BITS-1:0] word_data;
    logic                 word_csw;
    logic                 word_valid;
    logic                 parity_err;
    logic                 manch_err;
    logic                 rx_busy;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic                 csw;
        logic                 perr;
        logic                 merr;
        int                   cyc;
    } exp_t;

    exp_t                 exp_q[$];
    exp_t                 mon_e;
    logic [DATA_BITS-1:0] last_data = '0;
    int                   cyc = 0;
    int                   vectors = 0;
    int                   miscompares = 0;

    manchester_rx_decoder #(.SPB(SPB), .DATA_BITS(DATA_BITS)) dut (
        .dec_clk    (dec_clk),
        .reset_n    (reset_n),
        .rx_p       (rx_p),
        .rx_n       (rx_n),
        .enable     (enable),
        .word_data  (word_data),
        .word_csw   (word_csw),
        .word_valid (word_valid),
        .parity_err (parity_err),
        .manch_err  (manch_err),
        .rx_busy    (rx_busy)
    );

    always #5 dec_clk = ~dec_clk;

    always @(posedge dec_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

    task automatic play_sample(input logic lvl);
        @(negedge dec_clk);
        rx_p = lvl;
        rx_n = ~lvl;
    endtask

    // Idle alternates between both-low and both-high legs; both must read as 0.
    task automatic play_idle(input int n);
        repeat (n) begin
            @(negedge dec_clk);
            rx_p = 1'($urandom % 2);
            rx_n = rx_p;
        end
    endtask

    // A single '1' bit before a command sync breaks up idle zeros, which would
    // otherwise look like a data sync against the sync's leading ones.
    task automatic play_preamble();
        repeat (SPB / 2) play_sample(1'b1);
        repeat (SPB / 2) play_sample(1'b0);
    endtask

    task automatic applyStimulus(input logic csw, input logic [DATA_BITS-1:0] data, input logic par_bit,
                                 input int bad_bit, input logic bad_lvl, input int stop_bit);
        exp_t e;
        logic w;
        int   ones;
        repeat (3 * SPB / 2) play_sample(csw);
        repeat (3 * SPB / 2) play_sample(~csw);
        e.cyc  = cyc + PIPE_EDGES + LATENCY;
        e.data = '0;
        ones   = 0;
        for (int i = 0; i <= DATA_BITS; i++) begin
            if (i < DATA_BITS) w = data[DATA_BITS-1-i];
            else w = par_bit;
            if (i == bad_bit) w = bad_lvl;
            if (i < DATA_BITS) e.data[DATA_BITS-1-i] = w;
            ones += int'(w);
        end
        e.csw  = csw;
        e.perr = (ones % 2 == 0);
        e.merr = (bad_bit >= 0 && bad_bit <= DATA_BITS);
        if (stop_bit > DATA_BITS) begin
            exp_q.push_back(e);
            last_data = e.data;
        end
        for (int i = 0; i <= DATA_BITS && i < stop_bit; i++) begin
            if (i < DATA_BITS) w = data[DATA_BITS-1-i];
            else w = par_bit;
            if (i == bad_bit) begin
                repeat (SPB) play_sample(bad_lvl);
            end else begin
                repeat (SPB / 2) play_sample(w);
                repeat (SPB / 2) play_sample(~w);
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) play_idle(1);
        checkOutput("word_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_cleared(input string pfx);
        checkOutput({pfx, "_data"},  32'(word_data),  32'd0);
        checkOutput({pfx, "_csw"},   32'(word_csw),   32'd0);
        checkOutput({pfx, "_valid"}, 32'(word_valid), 32'd0);
        checkOutput({pfx, "_perr"},  32'(parity_err), 32'd0);
        checkOutput({pfx, "_merr"},  32'(manch_err),  32'd0);
        checkOutput({pfx, "_busy"},  32'(rx_busy),    32'd0);
    endtask

    always @(negedge dec_clk) begin
        if (reset_n === 1'b1 && word_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", 32'(word_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("word_data", 32'(word_data), 32'(mon_e.data));
                checkOutput("word_csw", 32'(word_csw), 32'(mon_e.csw));
                checkOutput("parity_err", 32'(parity_err), 32'(mon_e.perr));
                checkOutput("manch_err", 32'(manch_err), 32'(mon_e.merr));
                checkOutput("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        logic [DATA_BITS-1:0] r_data;
        logic                 r_csw;
        logic                 r_par;
        logic                 r_lvl;
        int                   r_bad;
        int                   r_gap;

        play_idle(4);
        check_cleared("reset");
        reset_n = 1'b1;
        enable  = 1'b1;
        play_idle(30);

        play_preamble();
        applyStimulus(1'b1, 16'h8421, 1'b1, -1, 1'b0, 99);
        wait_drain();

        play_idle(10);
        applyStimulus(1'b0, 16'hFFFF, 1'b1, -1, 1'b0, 99);
        play_idle(20);
        applyStimulus(1'b0, 16'hFFFF, 1'b0, -1, 1'b0, 99);
        wait_drain();

        play_idle(10);
        play_preamble();
        applyStimulus(1'b1, 16'h1234, odd_parity(16'h1234), 5, 1'b1, 99);
        wait_drain();

        play_idle(10);
        play_preamble();
        applyStimulus(1'b1, 16'h0001, odd_parity(16'h0001), -1, 1'b0, 99);
        applyStimulus(1'b0, 16'hA5A5, odd_parity(16'hA5A5), -1, 1'b0, 99);
        wait_drain();
        play_idle(200);

        play_preamble();
        applyStimulus(1'b1, 16'h5A3C, odd_parity(16'h5A3C), -1, 1'b0, 8);
        checkOutput("busy_before_reset", 32'(rx_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_cleared("in_reset");
        play_idle(3);
        reset_n   = 1'b1;
        last_data = '0;
        play_idle(40);
        check_cleared("after_reset");

        applyStimulus(1'b0, 16'h3C5A, odd_parity(16'h3C5A), -1, 1'b0, 99);
        wait_drain();
        play_idle(10);
        applyStimulus(1'b0, 16'hBEEF, odd_parity(16'hBEEF), -1, 1'b0, 8);
        checkOutput("busy_before_disable", 32'(rx_busy), 32'd1);
        enable = 1'b0;
        play_idle(4);
        checkOutput("busy_after_disable", 32'(rx_busy), 32'd0);
        checkOutput("data_retained", 32'(word_data), 32'(last_data));
        enable = 1'b1;
        play_idle(30);
        play_preamble();
        applyStimulus(1'b1, 16'h7E81, odd_parity(16'h7E81), -1, 1'b0, 99);
        wait_drain();

        play_idle(15);
        applyStimulus(1'b0, 16'h0FFF, odd_parity(16'h0FFF), -1, 1'b0, 99);
        applyStimulus(1'b1, 16'hF000, odd_parity(16'hF000), -1, 1'b0, 99);
        applyStimulus(1'b0, 16'hF000, odd_parity(16'hF000), -1, 1'b0, 99);
        wait_drain();
        play_idle(150);

        for (int k = 0; k < 12; k++) begin
            r_data = DATA_BITS'($urandom);
            r_csw  = 1'($urandom % 2);
            r_par  = odd_parity(r_data) ^ ($urandom % 5 == 0);
            r_bad  = ($urandom % 4 == 0) ? int'($urandom_range(0, 12)) : -1;
            r_lvl  = 1'($urandom % 2);
            r_gap  = (k != 0 && $urandom % 3 == 0) ? 0 : int'($urandom_range(5, 40));
            if (r_gap > 0) begin
                play_idle(r_gap);
                if (r_csw) play_preamble();
            end
            applyStimulus(r_csw, r_data, r_par, r_bad, r_lvl, 99);
        end
        wait_drain();
        play_idle(60);
        checkOutput("pending_words", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/manchester_rx_decoder.md
Name: manchester_rx_decoder

Overview:
- Receive-side word decoder that consumes one differential Manchester II bus pair (rx_p/rx_n, as delivered by the bus transceiver to the passthru stage).
- Samples the pair on the 8 MHz decode clock (8 samples per 1 Mbit/s bit).
- Detects command/status or data sync, recovers 16 data bits plus odd parity, and presents each word with error flags to downstream word-handling logic.
- One instance per bus (A and B).

Parameters:
- SPB, 8, samples per bit time; must be a multiple of 4, at least 8.
- DATA_BITS, 16, data bits per word (MSB first on the wire).

Ports:
- dec_clk  in  1  decode sample clock (8 MHz).
- reset_n  in  1  asynchronous active-low reset.
- rx_p  in  1  bus pair positive leg, asynchronous to dec_clk.
- rx_n  in  1  bus pair negative leg, asynchronous to dec_clk.
- enable  in  1  decode enable; when low, the decoder is held in HUNT.
- word_data  out  DATA_BITS  last decoded data word.
- word_csw  out  1  1 = command/status sync; 0 = data sync.
- word_valid  out  1  one-cycle pulse marking word_data, word_csw and the error flags valid.
- parity_err  out  1  qualifies word_valid: odd parity failed.
- manch_err  out  1  qualifies word_valid: at least one bit had equal half-bit levels.
- rx_busy  out  1  high while in BITS state.

Behaviour:
- Reset: all outputs 0, state HUNT, synchronisers, history and counters 0.
- Input path: rx_p and rx_n each pass through a 2-flop synchroniser. Line level d = rx_p_s AND NOT rx_n_s, so an idle or undriven bus reads 0.
- History: d shifts into a 3*SPB sample history every cycle in every state. Sync can therefore be found immediately after a word (back-to-back words, no gap).
- HUNT:
  - History (oldest to newest) equal to 1.5*SPB ones then 1.5*SPB zeros: command/status sync, csw = 1.
  - Exact inverse: data sync, csw = 0.
  - Either match with enable = 1: go to BITS next cycle; sample counter = 0, bit counter = 0, error accumulator cleared.
- BITS:
  - Sync matching is ignored.
  - Sample counter runs 0..SPB-1.
  - Capture first-half level at count SPB/4 and second-half level at count 3*SPB/4.
  - At count SPB-1 the bit resolves:
    - first = 1, second = 0: bit value 1.
    - first = 0, second = 1: bit value 0.
    - halves equal: bit value = first half, and the Manchester error accumulator is set.
  - Bits 0..DATA_BITS-1 shift into the data register MSB first; bit DATA_BITS is the parity bit.
- Word completion: on the cycle after the parity bit resolves:
  - word_valid = 1 for exactly one cycle.
  - word_data and word_csw are updated and held until the next word.
  - parity_err = 1 iff the total count of 1s across the DATA_BITS + 1 bits is even.
  - manch_err = accumulator value.
  - State returns to HUNT.
  - parity_err and manch_err are held until the next word_valid.
- Latency: word_valid rises (DATA_BITS+1)*SPB + 1 dec_clk cycles after the cycle in which sync matched.
- enable deasserted in BITS: abort to HUNT next cycle, no word_valid, outputs unchanged.
- reset_n asserted mid-word: immediate return to reset values; no partial word is ever emitted.
- A sync pattern embedded in data while in BITS has no effect.
- Counter widths: sample counter is clog2(SPB) bits; bit counter is clog2(DATA_BITS+1) bits. Neither wraps inside a word.

Test Plan:
- Reset, enable = 1, then command sync + 0x8421 + parity 1 -> one word_valid pulse; word_data = 0x8421, word_csw = 1, parity_err = 0, manch_err = 0, latency 137 cycles from sync match.
- Data sync + 0xFFFF + parity 1 -> word_csw = 0, word_data = 0xFFFF, no errors. Repeat with parity 0 -> parity_err = 1, word_valid still pulses.
- Command sync + 0x1234 with bit 5 driven high for both halves -> manch_err = 1, word_valid pulses.
- Two back-to-back words (command 0x0001, then data 0xA5A5) with no gap -> two word_valid pulses exactly 160 cycles apart with correct data and csw; a third idle period produces no pulse.
- reset_n low at bit 8 of a word, then released -> no word_valid, all outputs 0. enable low at bit 8 -> no word_valid, previous word_data retained, next full word decodes normally.
- Idle bus (rx_p = rx_n = 0) and data bits containing the pattern 0x0FFF/0xF000 -> no spurious sync or word_valid.
